// File: rtl/matrix_stream_adapter_pkg.sv
// Shared constants and controller state encoding for matrix_stream_adapter.
// Also provides the element index width helper.
package matrix_stream_pkg;

    localparam int ELEMENT_LENGTH = 32;

    typedef enum logic [2:0] {
        FILL_A = 3'd0,
        FILL_B = 3'd1,
        LOAD   = 3'd2,
        WAIT   = 3'd3,
        ACK    = 3'd4,
        DRAIN  = 3'd5
    } state_t;

    function automatic int idx_width(input int na, input int nb, input int nr);
        int m;
        m = na;
        if (nb > m) m = nb;
        if (nr > m) m = nr;
        return ($clog2(m) < 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/matrix_stream_adapter_if.sv
// Host stream and multiplier-side buses of matrix_stream_adapter.
// master is the adapter side, slave is the host/multiplier side.
interface matrix_stream_adapter_if #(
    parameter int NUM_FIRST_ROW  = 2,
    parameter int NUM_FIRST_COL  = 2,
    parameter int NUM_SECOND_COL = 2
);
    import matrix_stream_pkg::*;

    localparam int LEN_A = ELEMENT_LENGTH * NUM_FIRST_ROW * NUM_FIRST_COL;
    localparam int LEN_B = ELEMENT_LENGTH * NUM_FIRST_COL * NUM_SECOND_COL;
    localparam int LEN_R = ELEMENT_LENGTH * NUM_FIRST_ROW * NUM_SECOND_COL;

    logic [ELEMENT_LENGTH-1:0] in_data;
    logic                      in_stb;
    logic                      in_ack;
    logic [LEN_A-1:0]          In1;
    logic [LEN_B-1:0]          In2;
    logic                      load;
    logic [LEN_R-1:0]          Out;
    logic                      out_ready;
    logic                      out_ack;
    logic [ELEMENT_LENGTH-1:0] res_data;
    logic                      res_stb;
    logic                      res_ack;

    modport master (
        input  in_data, in_stb, Out, out_ready, res_ack,
        output in_ack, In1, In2, load, out_ack, res_data, res_stb
    );

    modport slave (
        output in_data, in_stb, Out, out_ready, res_ack,
        input  in_ack, In1, In2, load, out_ack, res_data, res_stb
    );

endinterface

// File: rtl/matrix_stream_adapter_shift_reg.sv
// Element-granular shift register: parallel load, shift-in at the LSB
// slice, shift-out from the MSB slice, with a tap on the MSB element.
module element_shift_reg
    import matrix_stream_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            load_en,
    input  logic [ELEMENT_LENGTH*DEPTH-1:0] load_data,
    input  logic                            shift_en,
    input  logic [ELEMENT_LENGTH-1:0]       shift_in,
    output logic [ELEMENT_LENGTH*DEPTH-1:0] data,
    output logic [ELEMENT_LENGTH-1:0]       msb
);

    localparam int W = ELEMENT_LENGTH * DEPTH;

    logic [W-1:0] q;
    logic [W-1:0] shifted;

    if (DEPTH == 1) begin : g_single
        assign shifted = shift_in;
    end else begin : g_multi
        assign shifted = {q[W-ELEMENT_LENGTH-1:0], shift_in};
    end

    // Storage: load wins over shift, reset clears everything.
    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= '0;
        end else if (load_en) begin
            q <= load_data;
        end else if (shift_en) begin
            q <= shifted;
        end
    end

    assign data = q;
    assign msb  = q[W-1 -: ELEMENT_LENGTH];

endmodule

// File: rtl/matrix_stream_adapter.sv
// Streams two operand matrices into a matrix multiplier, runs the
// load/out_ready/out_ack exchange and streams the result back out.
module matrix_stream_adapter
    import matrix_stream_pkg::*;
#(
    parameter int NUM_FIRST_ROW  = 2,
    parameter int NUM_FIRST_COL  = 2,
    parameter int NUM_SECOND_COL = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    matrix_stream_adapter_if.master bus,
    output logic                    busy
);

    localparam int NA   = NUM_FIRST_ROW * NUM_FIRST_COL;
    localparam int NB   = NUM_FIRST_COL * NUM_SECOND_COL;
    localparam int NR   = NUM_FIRST_ROW * NUM_SECOND_COL;
    localparam int IDXW = idx_width(NA, NB, NR);

    localparam logic [IDXW-1:0] LAST_A = IDXW'(NA - 1);
    localparam logic [IDXW-1:0] LAST_B = IDXW'(NB - 1);
    localparam logic [IDXW-1:0] LAST_R = IDXW'(NR - 1);

    state_t                    state;
    state_t                    state_next;
    logic [IDXW-1:0]           idx;
    logic [IDXW-1:0]           idx_next;
    logic                      take_in;
    logic                      a_shift;
    logic                      b_shift;
    logic                      capture;
    logic                      res_shift;
    logic [ELEMENT_LENGTH-1:0] res_msb;

    assign take_in   = bus.in_stb & bus.in_ack;
    assign a_shift   = take_in & (state == FILL_A);
    assign b_shift   = take_in & (state == FILL_B);
    assign capture   = (state == WAIT) & bus.out_ready & rst;
    assign res_shift = bus.res_stb & bus.res_ack;

    element_shift_reg #(.DEPTH(NA)) u_in1 (
        .clk       (clk),
        .rst       (rst),
        .load_en   (1'b0),
        .load_data ('0),
        .shift_en  (a_shift),
        .shift_in  (bus.in_data),
        .data      (bus.In1),
        .msb       ()
    );

    element_shift_reg #(.DEPTH(NB)) u_in2 (
        .clk       (clk),
        .rst       (rst),
        .load_en   (1'b0),
        .load_data ('0),
        .shift_en  (b_shift),
        .shift_in  (bus.in_data),
        .data      (bus.In2),
        .msb       ()
    );

    element_shift_reg #(.DEPTH(NR)) u_res (
        .clk       (clk),
        .rst       (rst),
        .load_en   (capture),
        .load_data (bus.Out),
        .shift_en  (res_shift),
        .shift_in  ('0),
        .data      (),
        .msb       (res_msb)
    );

    // State and element index registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= FILL_A;
            idx   <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
        end
    end

    // Next state: advance per accepted element, wrap idx at each phase end.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        case (state)
            FILL_A: begin
                if (take_in) begin
                    if (idx == LAST_A) begin
                        state_next = FILL_B;
                        idx_next   = '0;
                    end else begin
                        idx_next = idx + 1'b1;
                    end
                end
            end
            FILL_B: begin
                if (take_in) begin
                    if (idx == LAST_B) begin
                        state_next = LOAD;
                        idx_next   = '0;
                    end else begin
                        idx_next = idx + 1'b1;
                    end
                end
            end
            LOAD: begin
                state_next = WAIT;
            end
            WAIT: begin
                if (bus.out_ready) begin
                    state_next = ACK;
                end
            end
            ACK: begin
                state_next = DRAIN;
                idx_next   = '0;
            end
            DRAIN: begin
                if (res_shift) begin
                    if (idx == LAST_R) begin
                        state_next = FILL_A;
                        idx_next   = '0;
                    end else begin
                        idx_next = idx + 1'b1;
                    end
                end
            end
            default: begin
                state_next = FILL_A;
                idx_next   = '0;
            end
        endcase
    end

    // Handshake outputs decoded from state, all held low during reset.
    always_comb begin
        bus.in_ack  = 1'b0;
        bus.load    = 1'b0;
        bus.out_ack = 1'b0;
        bus.res_stb = 1'b0;
        busy        = 1'b0;
        if (rst) begin
            case (state)
                FILL_A: bus.in_ack = 1'b1;
                FILL_B: begin
                    bus.in_ack = 1'b1;
                    busy       = 1'b1;
                end
                LOAD: begin
                    bus.load = 1'b1;
                    busy     = 1'b1;
                end
                WAIT: busy = 1'b1;
                ACK: begin
                    bus.out_ack = 1'b1;
                    busy        = 1'b1;
                end
                DRAIN: begin
                    bus.res_stb = 1'b1;
                    busy        = 1'b1;
                end
                default: busy = 1'b1;
            endcase
        end
    end

    assign bus.res_data = rst ? res_msb : '0;

endmodule

// File: tb/tb_matrix_stream_adapter.sv
// Self-checking bench for matrix_stream_adapter: a 2x2x2 and a 2x3x1 instance
// with a latency-programmable multiplier model and a result scoreboard.
module tb_matrix_stream_adapter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic busy_m;
    logic busy_n;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] exp_q [$];

    int mlat    = 20;
    int mcnt    = -1;
    int ncnt    = -1;
    int loads_m = 0;

    logic [127:0] mout = '0;
    logic [63:0]  nout = '0;

    always #5 clk = ~clk;

    matrix_stream_adapter_if #(
        .NUM_FIRST_ROW(2), .NUM_FIRST_COL(2), .NUM_SECOND_COL(2)
    ) sq ();

    matrix_stream_adapter_if #(
        .NUM_FIRST_ROW(2), .NUM_FIRST_COL(3), .NUM_SECOND_COL(1)
    ) ns ();

    matrix_stream_adapter #(
        .NUM_FIRST_ROW(2), .NUM_FIRST_COL(2), .NUM_SECOND_COL(2)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (sq),
        .busy (busy_m)
    );

    matrix_stream_adapter #(
        .NUM_FIRST_ROW(2), .NUM_FIRST_COL(3), .NUM_SECOND_COL(1)
    ) dut_ns (
        .clk  (clk),
        .rst  (rst),
        .bus  (ns),
        .busy (busy_n)
    );

    // Count load pulses on the square instance.
    always @(posedge clk) begin
        if (sq.load === 1'b1) loads_m <= loads_m + 1;
    end

    // Multiplier model, square instance.
    always @(negedge clk) begin
        if (sq.out_ack === 1'b1) sq.out_ready = 1'b0;
        if (sq.load === 1'b1) begin
            mcnt = mlat;
        end else if (mcnt > 0) begin
            mcnt = mcnt - 1;
            if (mcnt == 0) begin
                sq.Out       = mout;
                sq.out_ready = 1'b1;
                mcnt         = -1;
            end
        end
    end

    // Multiplier model, non-square instance.
    always @(negedge clk) begin
        if (ns.out_ack === 1'b1) ns.out_ready = 1'b0;
        if (ns.load === 1'b1) begin
            ncnt = mlat;
        end else if (ncnt > 0) begin
            ncnt = ncnt - 1;
            if (ncnt == 0) begin
                ns.Out       = nout;
                ns.out_ready = 1'b1;
                ncnt         = -1;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic f_in_ack(input int w);
        return (w == 0) ? sq.in_ack : ns.in_ack;
    endfunction

    function automatic logic f_out_ack(input int w);
        return (w == 0) ? sq.out_ack : ns.out_ack;
    endfunction

    function automatic logic f_res_stb(input int w);
        return (w == 0) ? sq.res_stb : ns.res_stb;
    endfunction

    function automatic logic [31:0] f_res_data(input int w);
        return (w == 0) ? sq.res_data : ns.res_data;
    endfunction

    task automatic set_in(input int w, input logic stb, input logic [31:0] d);
        if (w == 0) begin
            sq.in_stb  = stb;
            sq.in_data = d;
        end else begin
            ns.in_stb  = stb;
            ns.in_data = d;
        end
    endtask

    task automatic set_res_ack(input int w, input logic v);
        if (w == 0) sq.res_ack = v;
        else        ns.res_ack = v;
    endtask

    task automatic send(input int w, input logic [31:0] d);
        int t;
        t = 0;
        set_in(w, 1'b1, d);
        while (f_in_ack(w) !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        vectors++;
        if (t >= 50) begin
            miscompares++;
            $display("FAIL send_timeout: in_ack low for %0d cycles, required 1", t);
        end
        @(negedge clk);
        set_in(w, 1'b0, 32'h0);
    endtask

    task automatic wait_out_ack(input int w, input bit poke);
        int t;
        t = 0;
        while (f_out_ack(w) !== 1'b1 && t < 200) begin
            if (poke) begin
                set_in(w, 1'b1, 32'hBAD0_0000 + 32'(t));
                vectors++;
                if (f_in_ack(w) !== 1'b0) begin
                    miscompares++;
                    $display("FAIL in_ack_outside_fill: got %b required 0", f_in_ack(w));
                end
            end
            @(negedge clk);
            t++;
        end
        set_in(w, 1'b0, 32'h0);
        vectors++;
        if (t >= 200) begin
            miscompares++;
            $display("FAIL out_ack_timeout: out_ack low for %0d cycles, required 1", t);
        end
    endtask

    task automatic drain(input int w, input int cnt, input int stall);
        logic [31:0] e;
        for (int k = 0; k < cnt; k++) begin
            int t;
            t = 0;
            while (f_res_stb(w) !== 1'b1 && t < 50) begin
                @(negedge clk);
                t++;
            end
            vectors++;
            if (t >= 50) begin
                miscompares++;
                $display("FAIL res_stb_timeout: element %0d got stb=0 required 1", k);
            end
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else                  e = 32'hDEAD_BEEF;
            vectors++;
            if (f_res_data(w) !== e) begin
                miscompares++;
                $display("FAIL res_data[%0d]: got %h required %h", k, f_res_data(w), e);
            end
            for (int s = 0; s < stall; s++) begin
                set_res_ack(w, 1'b0);
                @(negedge clk);
                vectors++;
                if (f_res_stb(w) !== 1'b1 || f_res_data(w) !== e) begin
                    miscompares++;
                    $display("FAIL res_stall[%0d]: got stb=%b data=%h required 1 %h",
                             k, f_res_stb(w), f_res_data(w), e);
                end
            end
            set_res_ack(w, 1'b1);
            @(negedge clk);
            set_res_ack(w, 1'b0);
        end
    endtask

    task automatic run_job(input logic [127:0] a, input logic [127:0] b,
                           input logic [127:0] o, input int lat, input int stall);
        mout = o;
        mlat = lat;
        for (int k = 0; k < 4; k++) exp_q.push_back(o[127-32*k -: 32]);
        for (int k = 0; k < 4; k++) send(0, a[127-32*k -: 32]);
        for (int k = 0; k < 4; k++) send(0, b[127-32*k -: 32]);
        vectors++;
        if ({sq.load, sq.In1, sq.In2} !== {1'b1, a, b}) begin
            miscompares++;
            $display("FAIL job_load: got load=%b In1=%h In2=%h required 1 %h %h",
                     sq.load, sq.In1, sq.In2, a, b);
        end
        wait_out_ack(0, 1'b0);
        drain(0, 4, stall);
        vectors++;
        if (sq.res_stb !== 1'b0 || sq.in_ack !== 1'b1) begin
            miscompares++;
            $display("FAIL job_done: got res_stb=%b in_ack=%b required 0 1",
                     sq.res_stb, sq.in_ack);
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({sq.in_ack, sq.load, sq.out_ack, sq.res_stb, busy_m} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b required 00000",
                     {sq.in_ack, sq.load, sq.out_ack, sq.res_stb, busy_m});
        end
        vectors++;
        if (sq.res_data !== 32'h0 || sq.In1 !== 128'h0 || sq.In2 !== 128'h0) begin
            miscompares++;
            $display("FAIL reset_data: got res=%h In1=%h In2=%h required zeros",
                     sq.res_data, sq.In1, sq.In2);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if (sq.in_ack !== 1'b1 || busy_m !== 1'b0 || ns.in_ack !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release: got in_ack=%b busy=%b ns_in_ack=%b required 1 0 1",
                     sq.in_ack, busy_m, ns.in_ack);
        end
        @(negedge clk);
    endtask

    task automatic test_basic_load;
        logic [31:0] va [8];
        int l0;
        va = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
               32'h3F800000, 32'h00000000, 32'h00000000, 32'h3F800000};
        mout = 128'h3F800000_40000000_40400000_40800000;
        mlat = 20;
        for (int k = 0; k < 4; k++) exp_q.push_back(mout[127-32*k -: 32]);
        l0 = loads_m;
        for (int k = 0; k < 8; k++) begin
            if (k == 7) begin
                vectors++;
                if (sq.load !== 1'b0) begin
                    miscompares++;
                    $display("FAIL load_early: got %b required 0", sq.load);
                end
            end
            send(0, va[k]);
        end
        vectors++;
        if (sq.load !== 1'b1 || busy_m !== 1'b1 || sq.in_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL load_pulse: got load=%b busy=%b in_ack=%b required 1 1 0",
                     sq.load, busy_m, sq.in_ack);
        end
        vectors++;
        if (sq.In1 !== 128'h3F800000_40000000_40400000_40800000) begin
            miscompares++;
            $display("FAIL in1_pack: got %h required 3f800000400000004040000040800000",
                     sq.In1);
        end
        vectors++;
        if (sq.In2 !== 128'h3F800000_00000000_00000000_3F800000) begin
            miscompares++;
            $display("FAIL in2_pack: got %h required 3f80000000000000000000003f800000",
                     sq.In2);
        end
        @(negedge clk);
        vectors++;
        if (sq.load !== 1'b0 || loads_m - l0 != 1) begin
            miscompares++;
            $display("FAIL load_width: got load=%b pulses=%0d required 0 1",
                     sq.load, loads_m - l0);
        end
    endtask

    task automatic test_completion;
        wait_out_ack(0, 1'b0);
        @(negedge clk);
        vectors++;
        if (sq.out_ack !== 1'b0 || sq.res_stb !== 1'b1) begin
            miscompares++;
            $display("FAIL out_ack_width: got out_ack=%b res_stb=%b required 0 1",
                     sq.out_ack, sq.res_stb);
        end
        drain(0, 4, 0);
        vectors++;
        if (sq.in_ack !== 1'b1 || sq.res_stb !== 1'b0 || busy_m !== 1'b0) begin
            miscompares++;
            $display("FAIL completion_idle: got in_ack=%b res_stb=%b busy=%b required 1 0 0",
                     sq.in_ack, sq.res_stb, busy_m);
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL completion_queue: got %0d left required 0", exp_q.size());
        end
    endtask

    task automatic test_backpressure;
        logic [127:0] ea;
        logic [127:0] eb;
        logic [31:0]  d;
        int gaps;
        ea   = '0;
        eb   = '0;
        mout = 128'h11111111_22222222_33333333_44444444;
        mlat = 7;
        for (int k = 0; k < 4; k++) exp_q.push_back(mout[127-32*k -: 32]);
        for (int k = 0; k < 8; k++) begin
            gaps = $urandom_range(0, 2);
            for (int g = 0; g < gaps; g++) begin
                vectors++;
                if (sq.in_ack !== 1'b1) begin
                    miscompares++;
                    $display("FAIL gap_in_ack: got %b required 1", sq.in_ack);
                end
                @(negedge clk);
            end
            d = $urandom;
            if (k < 4) ea = {ea[95:0], d};
            else       eb = {eb[95:0], d};
            send(0, d);
        end
        vectors++;
        if (sq.In1 !== ea || sq.In2 !== eb) begin
            miscompares++;
            $display("FAIL bp_pack: got %h %h required %h %h", sq.In1, sq.In2, ea, eb);
        end
        wait_out_ack(0, 1'b1);
        drain(0, 4, 5);
        vectors++;
        if (sq.In1 !== ea || sq.In2 !== eb || sq.in_ack !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_hold: got %h %h in_ack=%b required %h %h 1",
                     sq.In1, sq.In2, sq.in_ack, ea, eb);
        end
    endtask

    task automatic test_reset_mid_drain;
        mout = 128'hA0000001_A0000002_A0000003_A0000004;
        mlat = 5;
        for (int k = 0; k < 4; k++) exp_q.push_back(mout[127-32*k -: 32]);
        for (int k = 0; k < 8; k++) send(0, 32'h100 + 32'(k));
        wait_out_ack(0, 1'b0);
        drain(0, 2, 0);
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (sq.In1 !== 128'h0 || sq.In2 !== 128'h0 || sq.res_stb !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_clear: got In1=%h In2=%h res_stb=%b required 0 0 0",
                     sq.In1, sq.In2, sq.res_stb);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if (sq.res_stb !== 1'b0 || sq.in_ack !== 1'b1 || busy_m !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_state: got res_stb=%b in_ack=%b busy=%b required 0 1 0",
                     sq.res_stb, sq.in_ack, busy_m);
        end
        exp_q.delete();
        @(negedge clk);
        run_job(128'h00000001_00000002_00000003_00000004,
                128'h00000005_00000006_00000007_00000008,
                128'hC0000001_C0000002_C0000003_C0000004, 4, 0);
    endtask

    task automatic test_back_to_back;
        int l0;
        l0 = loads_m;
        run_job(128'h3F800000_3F800000_3F800000_3F800000,
                128'h40000000_40000000_40000000_40000000,
                128'h41000000_41000000_41000000_41000000, 3, 0);
        vectors++;
        if (loads_m - l0 != 1 || sq.load !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_first: got pulses=%0d load=%b required 1 0",
                     loads_m - l0, sq.load);
        end
        run_job(128'h12345678_9ABCDEF0_0F0F0F0F_F0F0F0F0,
                128'h00000000_11111111_22222222_33333333,
                128'hDEADBEEF_CAFEBABE_01234567_89ABCDEF, 1, 1);
        vectors++;
        if (loads_m - l0 != 2) begin
            miscompares++;
            $display("FAIL b2b_second: got pulses=%0d required 2", loads_m - l0);
        end
    endtask

    task automatic test_non_square;
        nout = 64'h00000011_00000022;
        mlat = 4;
        exp_q.push_back(32'h00000011);
        exp_q.push_back(32'h00000022);
        for (int k = 1; k <= 9; k++) send(1, 32'(k));
        vectors++;
        if (ns.In1 !== {32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6}) begin
            miscompares++;
            $display("FAIL ns_in1: got %h required 1..6 packed", ns.In1);
        end
        vectors++;
        if (ns.In2 !== {32'd7, 32'd8, 32'd9} || ns.load !== 1'b1) begin
            miscompares++;
            $display("FAIL ns_in2: got %h load=%b required 7..9 packed 1",
                     ns.In2, ns.load);
        end
        wait_out_ack(1, 1'b0);
        drain(1, 2, 1);
        vectors++;
        if (ns.res_stb !== 1'b0 || ns.in_ack !== 1'b1 || busy_n !== 1'b0) begin
            miscompares++;
            $display("FAIL ns_done: got res_stb=%b in_ack=%b busy=%b required 0 1 0",
                     ns.res_stb, ns.in_ack, busy_n);
        end
    endtask

    initial begin
        sq.in_data   = '0;
        sq.in_stb    = 1'b0;
        sq.res_ack   = 1'b0;
        sq.Out       = '0;
        sq.out_ready = 1'b0;
        ns.in_data   = '0;
        ns.in_stb    = 1'b0;
        ns.res_ack   = 1'b0;
        ns.Out       = '0;
        ns.out_ready = 1'b0;

        test_reset();
        test_basic_load();
        test_completion();
        test_backpressure();
        test_reset_mid_drain();
        test_back_to_back();
        test_non_square();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
